// File: rtl/gates2_pkg.sv
// Shared types and constants for the gates2 self-test controller.
package gates2_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StCapture,
      StDone
   } state_e;

   // Expected gates2 result bus for each vector in table order.
   localparam logic [5:0] ExpV0 = 6'h15;  // a=0 b=0
   localparam logic [5:0] ExpV1 = 6'h1A;  // a=1 b=0
   localparam logic [5:0] ExpV2 = 6'h1A;  // a=0 b=1
   localparam logic [5:0] ExpV3 = 6'h29;  // a=1 b=1

   // Bit positions on the z bus.
   localparam int unsigned ZAnd  = 5;
   localparam int unsigned ZNand = 4;
   localparam int unsigned ZOr   = 3;
   localparam int unsigned ZNor  = 2;
   localparam int unsigned ZXor  = 1;
   localparam int unsigned ZXnor = 0;

   // Reference gate evaluation, handy when bringing up a new gates2 variant.
   function automatic logic [5:0] gates2_eval(logic a, logic b);
      logic [5:0] z;
      z        = '0;
      z[ZAnd]  = a & b;
      z[ZNand] = ~(a & b);
      z[ZOr]   = a | b;
      z[ZNor]  = ~(a | b);
      z[ZXor]  = a ^ b;
      z[ZXnor] = ~(a ^ b);
      return z;
   endfunction

endpackage

// File: rtl/gates2_vec_rom.sv
// Combinational vector table: index -> stimulus (a, b) and expected z.
module gates2_vec_rom
   import gates2_pkg::*;
(
   input  logic [1:0] idx_i,
   output logic       a_o,
   output logic       b_o,
   output logic [5:0] exp_z_o
);

   // Index order is {b, a}, so the stimulus bits fall straight out of the index.
   always_comb begin
      a_o     = idx_i[0];
      b_o     = idx_i[1];
      exp_z_o = ExpV0;
      unique case (idx_i)
         2'd0: exp_z_o = ExpV0;
         2'd1: exp_z_o = ExpV1;
         2'd2: exp_z_o = ExpV2;
         2'd3: exp_z_o = ExpV3;
         default: exp_z_o = ExpV0;
      endcase
   end

endmodule

// File: rtl/gates2_selftest_ctrl.sv
// Self-test sequencer for gates2: applies four vectors, lets each settle,
// captures and compares z_in, and reports pass/fail summary registers.
module gates2_selftest_ctrl
   import gates2_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [5:0] z_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [2:0] err_cnt,
   output logic [5:0] first_fail_z
);

   localparam logic [7:0] CntLoad = 8'(SETTLE_CYCLES - 1);

   state_e     state_q;
   logic [1:0] idx_q;
   logic [7:0] cnt_q;

   logic [1:0] nxt_idx;
   logic       nxt_a;
   logic       nxt_b;
   logic [5:0] nxt_exp_unused;
   logic       cur_a_unused;
   logic       cur_b_unused;
   logic [5:0] cur_exp;
   logic       mismatch;

   // From IDLE the next vector is 0; otherwise it is the one after the current.
   assign nxt_idx  = (state_q == StIdle) ? 2'd0 : idx_q + 2'd1;
   assign mismatch = (z_in != cur_exp);

   gates2_vec_rom u_rom_cur (
      .idx_i   (idx_q),
      .a_o     (cur_a_unused),
      .b_o     (cur_b_unused),
      .exp_z_o (cur_exp)
   );

   gates2_vec_rom u_rom_nxt (
      .idx_i   (nxt_idx),
      .a_o     (nxt_a),
      .b_o     (nxt_b),
      .exp_z_o (nxt_exp_unused)
   );

   // Sequencer FSM with all outputs registered; clr wins over everything.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q      <= StIdle;
         idx_q        <= 2'd0;
         cnt_q        <= 8'd0;
         a_out        <= 1'b0;
         b_out        <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         fail_mask    <= 4'd0;
         err_cnt      <= 3'd0;
         first_fail_z <= 6'd0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q      <= StSettle;
                  idx_q        <= 2'd0;
                  cnt_q        <= CntLoad;
                  a_out        <= nxt_a;
                  b_out        <= nxt_b;
                  busy         <= 1'b1;
                  pass         <= 1'b0;
                  fail_mask    <= 4'd0;
                  err_cnt      <= 3'd0;
                  first_fail_z <= 6'd0;
               end
            end
            StSettle: begin
               if (cnt_q == 8'd0) begin
                  state_q <= StCapture;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            StCapture: begin
               if (mismatch) begin
                  fail_mask[idx_q] <= 1'b1;
                  err_cnt          <= err_cnt + 3'd1;
                  if (err_cnt == 3'd0) begin
                     first_fail_z <= z_in;
                  end
               end
               if (idx_q == 2'd3) begin
                  state_q <= StDone;
                  done    <= 1'b1;
                  // Fold in the final capture, which is not in fail_mask yet.
                  pass    <= (fail_mask == 4'd0) && !mismatch;
               end else begin
                  state_q <= StSettle;
                  idx_q   <= idx_q + 2'd1;
                  cnt_q   <= CntLoad;
                  a_out   <= nxt_a;
                  b_out   <= nxt_b;
               end
            end
            StDone: begin
               state_q <= StIdle;
               idx_q   <= 2'd0;
               busy    <= 1'b0;
               a_out   <= 1'b0;
               b_out   <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   logic unused_sink;
   assign unused_sink = ^{cur_a_unused, cur_b_unused, nxt_exp_unused};

endmodule

// File: tb/tb_gates2_selftest_ctrl.sv
// Bench for gates2_selftest_ctrl with a behavioural gates2 and fault injection.
module tb_gates2_selftest_ctrl;

   logic       clk = 1'b0;
   logic       clr;
   logic       start;
   logic       start1;
   logic [5:0] z_in;
   logic [5:0] z1;
   logic       a_out, b_out, busy, done, pass;
   logic [3:0] fail_mask;
   logic [2:0] err_cnt;
   logic [5:0] first_fail_z;
   logic       a1, b1, busy1, done1, pass1;
   logic [3:0] fail_mask1;
   logic [2:0] err_cnt1;
   logic [5:0] first_fail_z1;

   bit         force0;
   logic [5:0] fmask [4];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gates2_selftest_ctrl dut (
      .clk          (clk),
      .clr          (clr),
      .start        (start),
      .z_in         (z_in),
      .a_out        (a_out),
      .b_out        (b_out),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .fail_mask    (fail_mask),
      .err_cnt      (err_cnt),
      .first_fail_z (first_fail_z)
   );

   gates2_selftest_ctrl #(.SETTLE_CYCLES(1)) dut1 (
      .clk          (clk),
      .clr          (clr),
      .start        (start1),
      .z_in         (z1),
      .a_out        (a1),
      .b_out        (b1),
      .busy         (busy1),
      .done         (done1),
      .pass         (pass1),
      .fail_mask    (fail_mask1),
      .err_cnt      (err_cnt1),
      .first_fail_z (first_fail_z1)
   );

   // Behavioural gates2: plain boolean operators on a, b.
   function automatic logic [5:0] golden(logic a, logic b);
      return {a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b)};
   endfunction

   always_comb begin
      z_in = golden(a_out, b_out) ^ fmask[{b_out, a_out}];
      if (force0) z_in = 6'h00;
   end
   assign z1 = golden(a1, b1);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".a"}, 32'(a_out), 0);
      chk({tag, ".b"}, 32'(b_out), 0);
      chk({tag, ".busy"}, 32'(busy), 0);
      chk({tag, ".done"}, 32'(done), 0);
      chk({tag, ".pass"}, 32'(pass), 0);
      chk({tag, ".mask"}, 32'(fail_mask), 0);
      chk({tag, ".cnt"}, 32'(err_cnt), 0);
      chk({tag, ".ffz"}, 32'(first_fail_z), 0);
   endtask

   // Reference outcome of a pass from the current fault setup.
   task automatic model(output bit p, output logic [3:0] fm, output int ec,
                        output logic [5:0] ff);
      logic       a, b;
      logic [5:0] good, z;
      fm = 4'd0;
      ec = 0;
      ff = 6'd0;
      for (int k = 0; k < 4; k++) begin
         a    = (k % 2) == 1;
         b    = (k / 2) == 1;
         good = golden(a, b);
         z    = force0 ? 6'h00 : (good ^ fmask[k]);
         if (z != good) begin
            fm[k] = 1'b1;
            if (ec == 0) ff = z;
            ec++;
         end
      end
      p = (ec == 0);
   endtask

   // One full pass on the default-parameter DUT with random start noise while busy.
   task automatic run_pass(input string tag);
      bit         p;
      logic [3:0] fm;
      int         ec, n, k;
      logic [5:0] ff;
      model(p, fm, ec, ff);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 60) begin
         k = (n - 1) / 5;
         chk({tag, ".busy_run"}, 32'(busy), 1);
         if (n <= 20) begin
            chk({tag, ".a_vec"}, 32'(a_out), 32'(k % 2));
            chk({tag, ".b_vec"}, 32'(b_out), 32'(k / 2));
         end
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk({tag, ".done_cycle"}, 32'(n), 21);
      chk({tag, ".busy_done"}, 32'(busy), 1);
      chk({tag, ".pass"}, 32'(pass), 32'(p));
      chk({tag, ".mask"}, 32'(fail_mask), 32'(fm));
      chk({tag, ".cnt"}, 32'(err_cnt), 32'(ec));
      chk({tag, ".ffz"}, 32'(first_fail_z), 32'(ff));
      @(negedge clk);
      chk({tag, ".idle_busy"}, 32'(busy), 0);
      chk({tag, ".idle_done"}, 32'(done), 0);
      chk({tag, ".idle_a"}, 32'(a_out), 0);
      chk({tag, ".idle_b"}, 32'(b_out), 0);
      chk({tag, ".hold_pass"}, 32'(pass), 32'(p));
      chk({tag, ".hold_mask"}, 32'(fail_mask), 32'(fm));
   endtask

   initial begin
      int   n, ndone;
      logic exp_done;
      clr    = 1'b1;
      start  = 1'b1;
      start1 = 1'b0;
      force0 = 1'b0;
      for (int i = 0; i < 4; i++) fmask[i] = 6'h00;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      clr   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk_reset("reset_idle");

      run_pass("golden0");
      run_pass("golden1");

      force0 = 1'b1;
      run_pass("force0");
      force0 = 1'b0;

      fmask[3] = 6'h01;  // 6'h29 -> 6'h28 on a=1,b=1 only
      run_pass("fault11");

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 4; i++)
            fmask[i] = ($urandom_range(0, 2) == 0) ? 6'h00 : 6'($urandom_range(1, 63));
         run_pass($sformatf("rand%0d", r));
      end

      // Abort mid-pass with clr, start held high alongside it.
      for (int i = 0; i < 4; i++) fmask[i] = 6'h00;
      force0 = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (n = 1; n <= 10; n++) begin
         chk("abort.no_done", 32'(done), 0);
         if (n < 10) @(negedge clk);
      end
      chk("abort.partial_cnt", 32'(err_cnt), 1);
      clr   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk_reset("abort");
      clr    = 1'b0;
      start  = 1'b0;
      force0 = 1'b0;
      run_pass("after_abort");

      // SETTLE_CYCLES=1, start held for cycles 0..49: passes accepted at 0,10,..,40.
      @(negedge clk);
      start1 = 1'b1;
      ndone  = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 50) start1 = 1'b0;
         exp_done = (c >= 9) && ((c - 9) % 10 == 0) && (c - 9 <= 49);
         chk($sformatf("held.done_c%0d", c), 32'(done1), 32'(exp_done));
         if (done1 === 1'b1) begin
            ndone++;
            chk("held.pass", 32'(pass1), 1);
         end
      end
      chk("held.num_done", 32'(ndone), 5);
      chk("held.idle_busy", 32'(busy1), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
